// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial shift driver and the
// downstream shift-register bench.
//   ser_state_t  - driver FSM state encoding
//   DEF_WIDTH    - default word width / downstream register depth
//   DEF_DIV      - default CLK cycles per serial bit period
package serial_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV   = 1;

endpackage

// File: rtl/serial_shift_driver_bit_period_counter.sv
// bit_period_counter: counts CLK cycles within one serial bit period.
//   CLK   - clock, rising edge
//   RST   - synchronous active-low reset
//   clear - restart the period at 0 (new word accepted)
//   run   - count enable (driver is shifting)
//   tick  - last cycle of the current bit period while running
module bit_period_counter #(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Wraps to 0 on the compare value, so it never counts past DIV-1.
  always_ff @(posedge CLK) begin
    if (!RST)
      div_cnt <= '0;
    else if (clear)
      div_cnt <= '0;
    else if (run) begin
      if (div_cnt == LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = run && (div_cnt == LAST);

endmodule

// File: rtl/serial_shift_driver.sv
// serial_shift_driver: serializes a parallel word, LSB first, into a
// right-shifting register (serial data enters the top bit). After WIDTH
// shifts word bit i sits in Q[i], and done pulses for one cycle.
//   CLK, RST    - clock (rising edge), synchronous active-low reset
//   in_data     - parallel word
//   in_valid    - in_data is valid
//   in_ready    - word accepted on an edge where in_valid && in_ready
//   serial_out  - downstream serial data, stable for a whole bit period
//   shift_out   - downstream shift enable, one CLK per bit
//   busy        - transfer in progress (SHIFT or DONE)
//   done        - one-cycle pulse after the final shift
module serial_shift_driver
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] hold;
  logic [BW-1:0]    bit_cnt;
  logic             accept;
  logic             tick;

  // in_ready is gated by RST so nothing is accepted while reset is held.
  assign in_ready = (state == IDLE) && RST;
  assign accept   = in_valid && in_ready;

  bit_period_counter #(.DIV(DIV)) u_period (
    .CLK   (CLK),
    .RST   (RST),
    .clear (accept),
    .run   (state == SHIFT),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (tick && (bit_cnt == LAST_BIT)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt parks at WIDTH-1 after the last shift; the next accept clears it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      hold    <= in_data;
      bit_cnt <= '0;
    end else if (tick && (bit_cnt != LAST_BIT)) begin
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  assign serial_out = (state == SHIFT) ? hold[bit_cnt] : 1'b0;
  assign shift_out  = tick;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_serial_shift_driver.sv
// Directed bench: one driver at DIV=1 and one at DIV=3, each feeding a
// 4-bit right-shifting register model (serial in at bit 3).
module tb_serial_shift_driver;

  logic       CLK;
  logic       RST;
  logic [3:0] d1, d3;
  logic       v1, v3;
  logic       rdy1, ser1, sh1, busy1, done1;
  logic       rdy3, ser3, sh3, busy3, done3;
  logic [3:0] q1, q3;
  int         nt, nf;

  serial_shift_driver #(.WIDTH(4), .DIV(1)) u1 (
    .CLK(CLK), .RST(RST), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .serial_out(ser1), .shift_out(sh1), .busy(busy1), .done(done1)
  );

  serial_shift_driver #(.WIDTH(4), .DIV(3)) u3 (
    .CLK(CLK), .RST(RST), .in_data(d3), .in_valid(v3), .in_ready(rdy3),
    .serial_out(ser3), .shift_out(sh3), .busy(busy3), .done(done3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Downstream registers: serial data enters Q3 and moves toward Q0.
  always @(posedge CLK) begin
    if (sh1) q1 <= {ser1, q1[3:1]};
    if (sh3) q3 <= {ser3, q3[3:1]};
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nt++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full DIV=1 transfer of w on u1, accept edge first, through in_ready return.
  task automatic xfer1(input string tag, input logic [3:0] w);
    d1 = w; v1 = 1'b1;
    chk({tag, "_rdy"}, {7'd0, rdy1}, 8'd1);
    step();
    v1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk({tag, "_ser"},   {7'd0, ser1},  {7'd0, w[c-1]});
      chk({tag, "_shift"}, {7'd0, sh1},   8'd1);
      chk({tag, "_busy"},  {7'd0, busy1}, 8'd1);
      step();
    end
    chk({tag, "_done"}, {7'd0, done1}, 8'd1);
    chk({tag, "_q"},    {4'd0, q1},    {4'd0, w});
    step();
    chk({tag, "_done_off"}, {7'd0, done1}, 8'd0);
    chk({tag, "_rdy_back"}, {7'd0, rdy1},  8'd1);
  endtask

  initial begin
    nt = 0; nf = 0;
    q1 = 4'd0; q3 = 4'd0;
    d1 = 4'd0; d3 = 4'd0; v1 = 1'b0; v3 = 1'b0;

    // Reset held for 2 cycles with in_valid high: nothing accepted.
    RST = 1'b0; v1 = 1'b1; d1 = 4'hF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_rdy",   {7'd0, rdy1},  8'd0);
      chk("rst_busy",  {7'd0, busy1}, 8'd0);
      chk("rst_shift", {7'd0, sh1},   8'd0);
      chk("rst_ser",   {7'd0, ser1},  8'd0);
      chk("rst_done",  {7'd0, done1}, 8'd0);
    end
    v1 = 1'b0; RST = 1'b1;
    #1;
    chk("rst_rdy_rel", {7'd0, rdy1}, 8'd1);
    step();
    chk("idle_busy",  {7'd0, busy1}, 8'd0);
    chk("idle_rdy3",  {7'd0, rdy3},  8'd1);
    chk("idle_busy3", {7'd0, busy3}, 8'd0);

    // Basic transfer, DIV=1.
    xfer1("basic", 4'b1011);

    // Divided rate, DIV=3.
    d3 = 4'b0110; v3 = 1'b1;
    step();
    v3 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk("div3_shift", {7'd0, sh3},   {7'd0, (c % 3) == 0});
      chk("div3_ser",   {7'd0, ser3},  {7'd0, d3[(c-1)/3]});
      chk("div3_done0", {7'd0, done3}, 8'd0);
      step();
    end
    chk("div3_done", {7'd0, done3}, 8'd1);
    chk("div3_q",    {4'd0, q3},    8'h06);
    step();
    chk("div3_rdy",  {7'd0, rdy3},  8'd1);

    // Busy rejection: 1111 held valid during a 0001 transfer.
    d1 = 4'b0001; v1 = 1'b1;
    step();
    d1 = 4'b1111;
    for (int c = 1; c <= 4; c++) begin
      chk("busy_rdy", {7'd0, rdy1}, 8'd0);
      chk("busy_ser", {7'd0, ser1}, {7'd0, c == 1});
      step();
    end
    chk("busy_done",   {7'd0, done1}, 8'd1);
    chk("busy_rdy_dn", {7'd0, rdy1},  8'd0);
    chk("busy_q",      {4'd0, q1},    8'h01);
    step();
    chk("busy_acc6", {7'd0, rdy1}, 8'd1);
    step();
    v1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("busy2_ser", {7'd0, ser1}, 8'd1);
      step();
    end
    chk("busy2_done", {7'd0, done1}, 8'd1);
    chk("busy2_q",    {4'd0, q1},    8'h0F);
    step();

    // Reset mid-transfer at cycle 2.
    d1 = 4'b1010; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    RST = 1'b0;
    #1;
    chk("abort_rdy_rst", {7'd0, rdy1}, 8'd0);
    step();
    chk("abort_busy",  {7'd0, busy1}, 8'd0);
    chk("abort_shift", {7'd0, sh1},   8'd0);
    chk("abort_ser",   {7'd0, ser1},  8'd0);
    chk("abort_done",  {7'd0, done1}, 8'd0);
    RST = 1'b1;
    #1;
    chk("abort_rdy", {7'd0, rdy1}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_nodone", {7'd0, done1}, 8'd0);
    end
    xfer1("recover", 4'b1001);

    // Back-to-back with continuous in_valid: A=5, then B=C.
    d1 = 4'h5; v1 = 1'b1;
    step();
    d1 = 4'hC;
    for (int c = 1; c <= 4; c++) step();
    chk("b2b_doneA", {7'd0, done1}, 8'd1);
    chk("b2b_qA",    {4'd0, q1},    8'h05);
    step();
    chk("b2b_rdyB", {7'd0, rdy1}, 8'd1);
    step();
    v1 = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      chk("b2b_nodone", {7'd0, done1}, 8'd0);
      step();
    end
    chk("b2b_doneB", {7'd0, done1}, 8'd1);
    chk("b2b_qB",    {4'd0, q1},    8'h0C);
    step();
    chk("b2b_end", {7'd0, done1}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
